// File: rtl/seq_booth_multiplier_if.sv
// rtl/seq_booth_multiplier_if.sv - start/busy/done handshake and operand/product bus for the sequential Booth multiplier
interface seq_booth_multiplier_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, multiplicand, multiplier,
      input  busy, done, product
   );

   modport slave (
      input  start, multiplicand, multiplier,
      output busy, done, product
   );
endinterface

// File: rtl/seq_booth_multiplier.sv
// rtl/seq_booth_multiplier.sv - sequential signed Booth multiplier, one recoding step per clock
// Radix-4 recoding (WIDTH/2 iterations) when BOOTH_RADIX4_EN is defined, radix-2 otherwise.
module seq_booth_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   seq_booth_multiplier_if.slave  bus
);
`ifdef BOOTH_RADIX4_EN
   localparam int ITER = WIDTH / 2;
`else
   localparam int ITER = WIDTH;
`endif
   // Two guard bits keep A exact for the most-negative operand and for the +/-2M radix-4 term.
   localparam int AW = WIDTH + 2;
   localparam int CW = $clog2(ITER + 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t                r_state;
   logic signed [AW-1:0]  r_a;
   logic [WIDTH-1:0]      r_q;
   logic [WIDTH-1:0]      r_m;
   logic                  r_qm1;
   logic [CW-1:0]         r_cnt;
   logic                  r_busy;
   logic                  r_done;
   logic [2*WIDTH-1:0]    r_product;

   logic signed [AW-1:0]  w_m_ext;
   logic signed [AW-1:0]  w_addend;
   logic signed [AW-1:0]  w_sum;
   logic signed [AW-1:0]  w_a_nxt;
   logic [WIDTH-1:0]      w_q_nxt;
   logic                  w_qm1_nxt;

   assign w_m_ext = {{2{r_m[WIDTH-1]}}, r_m};

   always_comb begin
      w_addend = '0;
`ifdef BOOTH_RADIX4_EN
      case ({r_q[1:0], r_qm1})
         3'b001, 3'b010: w_addend = w_m_ext;
         3'b011:         w_addend = {w_m_ext[AW-2:0], 1'b0};
         3'b100:         w_addend = -{w_m_ext[AW-2:0], 1'b0};
         3'b101, 3'b110: w_addend = -w_m_ext;
         default:        w_addend = '0;
      endcase
      w_sum     = r_a + w_addend;
      w_a_nxt   = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
      w_q_nxt   = {w_sum[1:0], r_q[WIDTH-1:2]};
      w_qm1_nxt = r_q[1];
`else
      case ({r_q[0], r_qm1})
         2'b01:   w_addend = w_m_ext;
         2'b10:   w_addend = -w_m_ext;
         default: w_addend = '0;
      endcase
      w_sum     = r_a + w_addend;
      w_a_nxt   = {w_sum[AW-1], w_sum[AW-1:1]};
      w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
      w_qm1_nxt = r_q[0];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_q       <= '0;
         r_m       <= '0;
         r_qm1     <= 1'b0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_product <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_m     <= bus.multiplicand;
                  r_q     <= bus.multiplier;
                  r_a     <= '0;
                  r_qm1   <= 1'b0;
                  r_cnt   <= CW'(ITER);
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_a   <= w_a_nxt;
               r_q   <= w_q_nxt;
               r_qm1 <= w_qm1_nxt;
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_product <= {w_a_nxt[WIDTH-1:0], w_q_nxt};
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.product = r_product;
endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb/tb_seq_booth_multiplier.sv - self-checking bench: transaction model plus directed literal vectors
module tb_seq_booth_multiplier;
   localparam int W = 8;
`ifdef BOOTH_RADIX4_EN
   localparam int ITER = W / 2;
`else
   localparam int ITER = W;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   seq_booth_multiplier_if #(.WIDTH(W)) bus ();
   seq_booth_multiplier #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [2*W-1:0] ref_mul(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
      logic signed [2*W-1:0] r;
      r = a * b;
      return r;
   endfunction

   // Transaction-level model: accept when idle, result appears ITER clocks later.
   logic           m_busy, m_done;
   logic [2*W-1:0] m_prod, m_pend;
   int             m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_prod <= '0;
         m_pend <= '0;
         m_cnt  <= 0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (bus.start) begin
               m_busy <= 1'b1;
               m_cnt  <= ITER;
               m_pend <= ref_mul(bus.multiplicand, bus.multiplier);
            end
         end else if (m_cnt == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_prod <= m_pend;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", bus.busy, m_busy);
         chk("done", bus.done, m_done);
         chk("product", bus.product, m_prod);
      end
   end

   task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic [2*W-1:0] exp,
                         input string name, input bit now, input bit poke);
      int lat;
      if (now) #1;
      else begin
         @(posedge clk);
         #2;
      end
      bus.start        = 1'b1;
      bus.multiplicand = m;
      bus.multiplier   = q;
      @(posedge clk);
      #2;
      bus.start        = 1'b0;
      bus.multiplicand = ~m;
      bus.multiplier   = q ^ 8'h5A;
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         #1;
         if (poke && lat == 2) begin
            bus.start        = 1'b1;
            bus.multiplicand = 8'd100;
            bus.multiplier   = 8'd100;
         end
         if (poke && lat == 3) bus.start = 1'b0;
         if (bus.done) break;
      end
      chk({name, "_latency"}, lat, ITER);
      chk({name, "_product"}, bus.product, exp);
   endtask

   logic [W-1:0] edge_vals [6];
   logic [W-1:0] ra, rb;
   int           seen;

   initial begin
      edge_vals = '{8'h7F, 8'h80, 8'h81, 8'hFF, 8'h00, 8'h01};
      bus.start = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", bus.busy, 1'b0);
      chk("reset_done", bus.done, 1'b0);
      chk("reset_product", bus.product, 16'h0000);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;

      run_op(8'd3,  8'd5,  16'h000F, "3x5",        1'b0, 1'b0);
      run_op(8'h80, 8'h80, 16'h4000, "m128xm128",  1'b0, 1'b0);
      run_op(8'h80, 8'h7F, 16'hC080, "m128x127",   1'b0, 1'b0);
      run_op(8'hFF, 8'h01, 16'hFFFF, "m1x1",       1'b0, 1'b0);
      run_op(8'h00, 8'hB3, 16'h0000, "0xm77",      1'b0, 1'b0);
      run_op(8'd25, 8'hFD, 16'hFFB5, "ignored",    1'b0, 1'b1);
      run_op(8'd6,  8'd7,  16'h002A, "first",      1'b0, 1'b0);
      run_op(8'hFB, 8'd9,  16'hFFD3, "b2b",        1'b1, 1'b0);

      @(posedge clk);
      #2;
      bus.start = 1'b1;
      bus.multiplicand = 8'd100;
      bus.multiplier   = 8'd100;
      @(posedge clk);
      #2;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_done", bus.done, 1'b0);
      chk("abort_product", bus.product, 16'h0000);
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (bus.done) seen++;
      end
      chk("abort_no_done", seen, 0);
      #1 rst_n = 1'b1;
      run_op(8'd7, 8'hF7, 16'hFFC1, "7xm9", 1'b0, 1'b0);

      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++)
            run_op(edge_vals[i], edge_vals[j], ref_mul(edge_vals[i], edge_vals[j]), "edge", 1'b0, 1'b0);
      for (int k = 0; k < 150; k++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         run_op(ra, rb, ref_mul(ra, rb), "rand", k[0], 1'b0);
      end

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/seq_booth_multiplier.md
# seq_booth_multiplier

- Sequential, parametrised signed Booth multiplier. Multiplies two WIDTH-bit two's-complement operands into a 2·WIDTH-bit product.
- Performs one Booth recoding step per clock over a single shared adder/subtractor, using a start/busy/done handshake.
- Sits in the arithmetic datapath in place of the fully unrolled 8-bit combinational multiplier, trading latency for area.
- Handles the most-negative operand correctly and optionally supports radix-4 recoding.

## Interface
- WIDTH, 8, operand width; must be ≥ 2 and even.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy = 0.
- multiplicand  input  WIDTH  signed operand M, captured on accept.
- multiplier  input  WIDTH  signed operand Q, captured on accept.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; product is valid.
- product  output  2·WIDTH  signed M×Q, registered and held until the next done.

## Operation
- States:
  - IDLE → RUN on start at a clock edge while busy = 0.
  - RUN → IDLE on the edge that completes the final iteration.
- Accept edge:
  - M_r ← multiplicand, Q_r ← multiplier.
  - A ← 0, where A is WIDTH+2 bits.
  - q_m1 ← 0, cnt ← ITER.
  - busy ← 1.
- Radix-2 iteration (ITER = WIDTH), once per RUN edge:
  - On {Q_r[0], q_m1}: 01 → A += sext(M_r); 10 → A −= sext(M_r); 00/11 → no add.
  - Then arithmetic-shift {A, Q_r, q_m1} right by 1, replicating A's MSB.
  - cnt −= 1.
- Width rule: A is sign-extended to WIDTH+2 bits, so −2^(WIDTH−1) operands never overflow. product = low 2·WIDTH bits of {A, Q_r} after the final shift.
- Final edge:
  - product ← result.
  - done ← 1 for exactly one cycle.
  - busy ← 0, state → IDLE.
- start while busy = 1 is ignored; it is neither queued nor does it disturb the operation.
- Operand inputs may change freely while busy = 1; only the captured copies are used.
- start asserted in the cycle where done = 1 is accepted, since busy = 0 in that cycle.
- Reset values: state IDLE; busy 0, done 0, product 0; A, Q_r, M_r, q_m1, cnt all 0.
- Reset mid-operation: the operation is aborted, no done is issued, and product is cleared to 0.

## Timing
- Accept at edge k.
  - busy is high for cycles after edges k … k+ITER−1.
  - done and the new product are visible after edge k+ITER; busy is 0 in that cycle.
- Latency is ITER clocks from the accept edge to done.
- Minimum issue period is ITER+1 clocks (back-to-back start in the done cycle).
- product changes only on a done edge or on reset.
- The critical path is one (WIDTH+2)-bit add/sub plus a mux.

## Configuration
- BOOTH_RADIX4_EN defined: radix-4 recoding with ITER = WIDTH/2.
  - Decode {Q_r[1], Q_r[0], q_m1}:
    - 000/111 → 0.
    - 001/010 → +M.
    - 011 → +2M.
    - 100 → −2M.
    - 101/110 → −M.
  - Then arithmetic-shift {A, Q_r, q_m1} right by 2, with q_m1 ← old Q_r[1].
  - A stays WIDTH+2 bits, which is sufficient for ±2M.
- BOOTH_RADIX4_EN undefined: radix-2 as described in Operation, with ITER = WIDTH.
- Ports, reset behaviour and handshake are identical in both builds.

## Test plan
- WIDTH=8, radix-2: M=3, Q=5 → product 0x000F, done exactly 8 edges after accept, one-cycle pulse.
- WIDTH=8, corner cases:
  - −128×−128 → 0x4000.
  - −128×127 → 0xC080.
  - −1×1 → 0xFFFF.
  - 0×−77 → 0x0000.
- Handshake:
  - start pulsed at RUN iteration 3 with new operands → ignored; first result is unchanged.
  - start in the done cycle → accepted; second result is correct 8 edges later.
- Reset: rst_n low during iteration 4 → busy=0, done=0 and product=0 immediately; no done follows; the next operation 7×−9 → 0xFFC1.
- WIDTH=16 with BOOTH_RADIX4_EN: 1234×−5678 → 0xFF951644, done 8 edges after accept.
- Both builds, WIDTH ∈ {4, 8, 16}: 1000 random operand pairs including ±max and min → product equals the signed reference multiply.
